data_sync_capture: RTL and testbench

Receive-side capture stage that sits directly downstream of the bit synchronizer in the multi-clock system. It takes the already-synchronized enable level, detects its active edge, and captures the quasi-static source-domain bus into the destination domain. It produces a one-cycle `Enable_pulse` and a held `Sync_valid`/`Sync_ready` handshake toward the consumer, and flags an overrun whenever a new transfer arrives before the previous word has been consumed.

---
 rtl/data_sync_capture_if.sv | 36 +++
 rtl/data_sync_capture.sv | 75 +++++++
 tb/tb_data_sync_capture.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/data_sync_capture_if.sv
// Handshake and data bundle between the enable/bus source, the capture stage and its consumer.
// The slave modport is the capture stage; master is the upstream/consumer side driving it.
interface data_sync_capture_if #(
   parameter int BUS_WIDTH = 8
);
   logic                 Enable_sync;
   logic [BUS_WIDTH-1:0] Unsync_bus;
   logic                 Sync_ready;
   logic                 Overrun_clr;
   logic [BUS_WIDTH-1:0] Sync_bus;
   logic                 Sync_valid;
   logic                 Enable_pulse;
   logic                 Overrun;

   modport slave (
      input  Enable_sync,
      input  Unsync_bus,
      input  Sync_ready,
      input  Overrun_clr,
      output Sync_bus,
      output Sync_valid,
      output Enable_pulse,
      output Overrun
   );

   modport master (
      output Enable_sync,
      output Unsync_bus,
      output Sync_ready,
      output Overrun_clr,
      input  Sync_bus,
      input  Sync_valid,
      input  Enable_pulse,
      input  Overrun
   );
endinterface

// File: rtl/data_sync_capture.sv
// Captures a quasi-static bus on the active edge of a pre-synchronized enable; outputs visible one cycle after the edge.
// Holds one word until Sync_ready; an edge arriving while full and not consumed is dropped and flags Overrun.
module data_sync_capture #(
   parameter int BUS_WIDTH   = 8,
   parameter int TOGGLE_MODE = 0
) (
   input  logic                 Sync_clk,
   input  logic                 Reg_reset,
   data_sync_capture_if.slave   bus
);

   typedef enum logic {EMPTY, FULL} state_e;

   state_e               state_q, state_d;
   logic                 en_prev_q;
   logic [BUS_WIDTH-1:0] sync_bus_q, sync_bus_d;
   logic                 pulse_q, pulse_d;
   logic                 overrun_q, overrun_d;
   logic                 edge_det;

   assign edge_det = (TOGGLE_MODE != 0) ? (bus.Enable_sync ^ en_prev_q)
                                        : (bus.Enable_sync & ~en_prev_q);

   always_ff @(posedge Sync_clk or negedge Reg_reset) begin
      if (!Reg_reset) begin
         state_q    <= EMPTY;
         en_prev_q  <= 1'b0;
         sync_bus_q <= '0;
         pulse_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         en_prev_q  <= bus.Enable_sync;
         sync_bus_q <= sync_bus_d;
         pulse_q    <= pulse_d;
         overrun_q  <= overrun_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sync_bus_d = sync_bus_q;
      pulse_d    = 1'b0;
      // A drop in the same cycle as a clear must leave the flag set, so the set is applied last.
      overrun_d  = overrun_q & ~bus.Overrun_clr;
      case (state_q)
         EMPTY: begin
            if (edge_det) begin
               sync_bus_d = bus.Unsync_bus;
               pulse_d    = 1'b1;
               state_d    = FULL;
            end
         end
         FULL: begin
            if (bus.Sync_ready) begin
               if (edge_det) begin
                  sync_bus_d = bus.Unsync_bus;
                  pulse_d    = 1'b1;
               end else begin
                  state_d    = EMPTY;
               end
            end else if (edge_det) begin
               overrun_d  = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   assign bus.Sync_bus     = sync_bus_q;
   assign bus.Sync_valid   = (state_q == FULL);
   assign bus.Enable_pulse = pulse_q;
   assign bus.Overrun      = overrun_q;

endmodule

// File: tb/tb_data_sync_capture.sv
// Directed bench driving a mode-0 and a mode-1 instance in lockstep against a transfer-level model.
module tb_data_sync_capture;

   logic clk;
   logic rst_n;

   data_sync_capture_if #(.BUS_WIDTH(8)) if0 ();
   data_sync_capture_if #(.BUS_WIDTH(8)) if1 ();

   data_sync_capture #(.BUS_WIDTH(8), .TOGGLE_MODE(0)) u_m0 (
      .Sync_clk (clk),
      .Reg_reset(rst_n),
      .bus      (if0)
   );

   data_sync_capture #(.BUS_WIDTH(8), .TOGGLE_MODE(1)) u_m1 (
      .Sync_clk (clk),
      .Reg_reset(rst_n),
      .bus      (if1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Transfer-level model, one slot per mode.
   logic       m_prev  [2];
   logic       m_valid [2];
   logic [7:0] m_data  [2];
   logic       m_pulse [2];
   logic       m_ovr   [2];
   int         pulse_cnt [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_prev[m]  = 1'b0;
         m_valid[m] = 1'b0;
         m_data[m]  = 8'h00;
         m_pulse[m] = 1'b0;
         m_ovr[m]   = 1'b0;
      end
   endtask

   task automatic read_dut(input int m, output logic [7:0] b, output logic v,
                           output logic p, output logic o);
      if (m == 0) begin
         b = if0.Sync_bus; v = if0.Sync_valid; p = if0.Enable_pulse; o = if0.Overrun;
      end else begin
         b = if1.Sync_bus; v = if1.Sync_valid; p = if1.Enable_pulse; o = if1.Overrun;
      end
   endtask

   task automatic compare_all(input string tag);
      logic [7:0] b;
      logic v, p, o;
      for (int m = 0; m < 2; m++) begin
         read_dut(m, b, v, p, o);
         check($sformatf("%s m%0d bus", tag, m), {24'h0, b}, {24'h0, m_data[m]});
         check($sformatf("%s m%0d valid", tag, m), {31'h0, v}, {31'h0, m_valid[m]});
         check($sformatf("%s m%0d pulse", tag, m), {31'h0, p}, {31'h0, m_pulse[m]});
         check($sformatf("%s m%0d overrun", tag, m), {31'h0, o}, {31'h0, m_ovr[m]});
         if (p === 1'b1) pulse_cnt[m]++;
      end
   endtask

   // Apply inputs for one clock, advance the model by the transfer rules, compare after the edge.
   task automatic step(input string tag, input logic en, input logic [7:0] d,
                       input logic rdy, input logic clr);
      logic ev, accept, drop;
      if0.Enable_sync = en; if0.Unsync_bus = d; if0.Sync_ready = rdy; if0.Overrun_clr = clr;
      if1.Enable_sync = en; if1.Unsync_bus = d; if1.Sync_ready = rdy; if1.Overrun_clr = clr;
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         ev     = (m == 1) ? (en != m_prev[m]) : (en && !m_prev[m]);
         accept = ev && (!m_valid[m] || rdy);
         drop   = ev && m_valid[m] && !rdy;
         if (accept) m_data[m] = d;
         m_valid[m] = accept || (m_valid[m] && !rdy);
         m_pulse[m] = accept;
         m_ovr[m]   = drop ? 1'b1 : (clr ? 1'b0 : m_ovr[m]);
         m_prev[m]  = en;
      end
      compare_all(tag);
   endtask

   task automatic check_all_zero(input string tag);
      logic [7:0] b;
      logic v, p, o;
      for (int m = 0; m < 2; m++) begin
         read_dut(m, b, v, p, o);
         check($sformatf("%s m%0d zero", tag, m), {21'h0, b, v, p, o}, 32'h0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      if0.Enable_sync = 1'b0; if0.Unsync_bus = 8'h00; if0.Sync_ready = 1'b0; if0.Overrun_clr = 1'b0;
      if1.Enable_sync = 1'b0; if1.Unsync_bus = 8'h00; if1.Sync_ready = 1'b0; if1.Overrun_clr = 1'b0;
      model_reset();
      pulse_cnt[0] = 0; pulse_cnt[1] = 0;
      #2;
      check_all_zero("reset");
      #6 rst_n = 1'b1;

      // Single mode-0 capture at edge 3, consume at edge 5.
      step("cap e1", 1'b0, 8'h00, 1'b0, 1'b0);
      step("cap e2", 1'b0, 8'h00, 1'b0, 1'b0);
      step("cap e3", 1'b1, 8'hA5, 1'b0, 1'b0);
      check("lit e3 bus",   {24'h0, if0.Sync_bus}, 32'hA5);
      check("lit e3 valid", {31'h0, if0.Sync_valid}, 32'h1);
      check("lit e3 pulse", {31'h0, if0.Enable_pulse}, 32'h1);
      step("cap e4", 1'b1, 8'hA5, 1'b0, 1'b0);
      check("lit e4 pulse", {31'h0, if0.Enable_pulse}, 32'h0);
      step("cap e5", 1'b1, 8'hA5, 1'b1, 1'b0);
      check("lit e5 valid", {31'h0, if0.Sync_valid}, 32'h0);
      check("lit e5 bus",   {24'h0, if0.Sync_bus}, 32'hA5);

      // Level held high for 10 cycles: one capture in mode 0.
      step("lvl low", 1'b0, 8'h00, 1'b1, 1'b0);
      pulse_cnt[0] = 0;
      for (int i = 0; i < 10; i++) step("lvl hi", 1'b1, 8'h5A, 1'b1, 1'b0);
      check("lit level pulses", pulse_cnt[0], 32'd1);
      check("lit level bus", {24'h0, if0.Sync_bus}, 32'h5A);

      // Overrun: capture 0x11, unconsumed second edge with 0x22.
      step("ovr low", 1'b0, 8'h00, 1'b1, 1'b0);
      step("ovr cap", 1'b1, 8'h11, 1'b0, 1'b0);
      step("ovr low2", 1'b0, 8'h11, 1'b0, 1'b0);
      step("ovr drop", 1'b1, 8'h22, 1'b0, 1'b0);
      check("lit drop bus",   {24'h0, if0.Sync_bus}, 32'h11);
      check("lit drop ovr",   {31'h0, if0.Overrun}, 32'h1);
      check("lit drop pulse", {31'h0, if0.Enable_pulse}, 32'h0);
      step("ovr clr", 1'b1, 8'h22, 1'b0, 1'b1);
      check("lit clr ovr", {31'h0, if0.Overrun}, 32'h0);
      step("ovr low3", 1'b0, 8'h00, 1'b0, 1'b0);
      step("ovr set+clr", 1'b1, 8'h55, 1'b0, 1'b1);
      check("lit set wins", {31'h0, if0.Overrun}, 32'h1);

      // Simultaneous consume and capture.
      step("sim consume", 1'b0, 8'h00, 1'b1, 1'b1);
      step("sim cap33", 1'b1, 8'h33, 1'b0, 1'b0);
      step("sim hold", 1'b0, 8'h33, 1'b0, 1'b0);
      step("sim cap44", 1'b1, 8'h44, 1'b1, 1'b0);
      check("lit sim bus",   {24'h0, if0.Sync_bus}, 32'h44);
      check("lit sim valid", {31'h0, if0.Sync_valid}, 32'h1);
      check("lit sim pulse", {31'h0, if0.Enable_pulse}, 32'h1);
      check("lit sim ovr",   {31'h0, if0.Overrun}, 32'h0);
      step("sim drain1", 1'b0, 8'h00, 1'b1, 1'b0);
      step("sim drain2", 1'b0, 8'h00, 1'b1, 1'b0);

      // Toggle mode: rise with 0x01, fall with 0x02, each consumed.
      pulse_cnt[1] = 0;
      step("tog rise", 1'b1, 8'h01, 1'b0, 1'b0);
      check("lit tog1 bus", {24'h0, if1.Sync_bus}, 32'h01);
      step("tog use1", 1'b1, 8'h01, 1'b1, 1'b0);
      step("tog fall", 1'b0, 8'h02, 1'b0, 1'b0);
      check("lit tog2 bus",   {24'h0, if1.Sync_bus}, 32'h02);
      check("lit tog2 pulse", {31'h0, if1.Enable_pulse}, 32'h1);
      step("tog use2", 1'b0, 8'h02, 1'b1, 1'b0);
      check("lit tog pulses", pulse_cnt[1], 32'd2);
      check("lit tog empty", {31'h0, if1.Sync_valid}, 32'h0);

      // Reset while FULL with Overrun set, release with enable still high.
      step("rst cap", 1'b1, 8'h66, 1'b0, 1'b0);
      step("rst low", 1'b0, 8'h66, 1'b0, 1'b0);
      step("rst drop", 1'b1, 8'h77, 1'b0, 1'b0);
      check("lit pre-rst ovr", {31'h0, if0.Overrun}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("async rst");
      model_reset();
      #3 rst_n = 1'b1;
      step("rst rel", 1'b1, 8'h77, 1'b0, 1'b0);
      check("lit rel bus",   {24'h0, if0.Sync_bus}, 32'h77);
      check("lit rel pulse", {31'h0, if0.Enable_pulse}, 32'h1);
      step("rst after", 1'b1, 8'h77, 1'b0, 1'b0);
      check("lit rel one pulse", {31'h0, if0.Enable_pulse}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
